// File: rtl/cfu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cfu_arbiter
// Purpose  : Round-robin arbiter sharing one CFU slave between NUM_REQ
//            requesters. Requests are forwarded combinationally from the
//            granted requester. The requester index of every accepted request
//            is queued in an in-order tag FIFO, and each CFU response is routed
//            back to the requester at the FIFO head.
// Ports    : clk, rst                   - clock, synchronous active-high reset
//            m_req_*_i / m_req_ready_o  - packed per-requester request side
//            m_lock_i                   - grant-hold request (lock build only)
//            m_resp_*_o / m_resp_ready_i- response side (one-hot valid)
//            s_req_*_o / s_req_ready_i  - CFU request side
//            s_resp_*_i / s_resp_ready_o- CFU response side
//            err_o                      - sticky: response with no outstanding tag
// Config   : `define CFU_ARB_LOCK_EN enables grant locking through m_lock_i
// Revision : 1.0 - initial release
// ============================================================================
module cfu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 4,
    parameter int FUNC_W  = 4,
    parameter int MAX_OUT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        m_req_valid_i,
    output logic [NUM_REQ-1:0]        m_req_ready_o,
    input  logic [NUM_REQ*ID_W-1:0]   m_req_id_i,
    input  logic [NUM_REQ*8-1:0]      m_req_cfu_i,
    input  logic [NUM_REQ*FUNC_W-1:0] m_req_func_i,
    input  logic [NUM_REQ*32-1:0]     m_req_data0_i,
    input  logic [NUM_REQ*32-1:0]     m_req_data1_i,
    input  logic [NUM_REQ-1:0]        m_lock_i,
    output logic [NUM_REQ-1:0]        m_resp_valid_o,
    input  logic [NUM_REQ-1:0]        m_resp_ready_i,
    output logic [ID_W-1:0]           m_resp_id_o,
    output logic                      m_resp_status_o,
    output logic [31:0]               m_resp_data_o,
    output logic                      s_req_valid_o,
    output logic [ID_W-1:0]           s_req_id_o,
    output logic [7:0]                s_req_cfu_o,
    output logic [FUNC_W-1:0]         s_req_func_o,
    output logic [31:0]               s_req_data0_o,
    output logic [31:0]               s_req_data1_o,
    input  logic                      s_req_ready_i,
    input  logic                      s_resp_valid_i,
    input  logic [ID_W-1:0]           s_resp_id_i,
    input  logic                      s_resp_status_i,
    input  logic [31:0]               s_resp_data_i,
    output logic                      s_resp_ready_o,
    output logic                      err_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW    = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic [PTR_W-1:0] rr_q, rr_d;
    logic [PTR_W-1:0] fifo_q [MAX_OUT];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic [NUM_REQ-1:0] eligible;
    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   gnt_idx;
    logic               gnt_found;
    logic               not_full;
    logic               not_empty;
    logic               push;
    logic               pop;
    logic [PTR_W-1:0]   head;

`ifdef CFU_ARB_LOCK_EN
    logic             lock_active_q, lock_active_d;
    logic [PTR_W-1:0] lock_owner_q, lock_owner_d;

    // While locked, only the owner is visible to the arbiter, even when idle.
    assign eligible = lock_active_q ? (m_req_valid_i & (NUM_REQ'(1) << lock_owner_q))
                                    : m_req_valid_i;
`else
    wire unused_lock = ^m_lock_i;
    assign eligible = m_req_valid_i;
`endif

    // First eligible requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_q) + k) % NUM_REQ);
            if (!gnt_found && eligible[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign not_full  = (count_q < CNT_W'(MAX_OUT));
    assign not_empty = (count_q != '0);
    assign head      = fifo_q[rd_q];

    // Request side: pure combinational mux from the granted requester.
    assign s_req_valid_o = gnt_found & not_full;
    assign s_req_id_o    = m_req_id_i[gnt_idx*ID_W +: ID_W];
    assign s_req_cfu_o   = m_req_cfu_i[gnt_idx*8 +: 8];
    assign s_req_func_o  = m_req_func_i[gnt_idx*FUNC_W +: FUNC_W];
    assign s_req_data0_o = m_req_data0_i[gnt_idx*32 +: 32];
    assign s_req_data1_o = m_req_data1_i[gnt_idx*32 +: 32];
    assign m_req_ready_o = (gnt_found && s_req_ready_i && not_full)
                           ? (NUM_REQ'(1) << gnt_idx) : '0;

    // Response side: only the FIFO head may see or accept the response.
    assign m_resp_valid_o  = (not_empty && s_resp_valid_i) ? (NUM_REQ'(1) << head) : '0;
    assign s_resp_ready_o  = m_resp_ready_i[head] & not_empty;
    assign m_resp_id_o     = s_resp_id_i;
    assign m_resp_status_o = s_resp_status_i;
    assign m_resp_data_o   = s_resp_data_i;
    assign err_o           = err_q;

    assign push = s_req_valid_o & s_req_ready_i;
    assign pop  = s_resp_valid_i & s_resp_ready_o;

    always_comb begin
        rr_d    = rr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        err_d   = err_q | (s_resp_valid_i & ~not_empty);
        if (push) begin
            rr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
            wr_d = (wr_q == AW'(MAX_OUT - 1)) ? '0 : wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = (rd_q == AW'(MAX_OUT - 1)) ? '0 : rd_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

`ifdef CFU_ARB_LOCK_EN
    always_comb begin
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        if (push) begin
            if (!lock_active_q && m_lock_i[gnt_idx]) begin
                lock_active_d = 1'b1;
                lock_owner_d  = gnt_idx;
            end else if (lock_active_q && !m_lock_i[gnt_idx]) begin
                // Releasing handshake is still issued normally.
                lock_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_active_q <= 1'b0;
            lock_owner_q  <= '0;
        end else begin
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Tag storage needs no reset: entries are only read while count_q > 0.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_q] <= gnt_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cfu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfu_arbiter
// Purpose  : Directed self-checking bench for cfu_arbiter (NUM_REQ=2,
//            MAX_OUT=2). Inputs change 1 ns after a rising edge, outputs are
//            checked 1 ns later. Lock scenario runs when CFU_ARB_LOCK_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfu_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 4;
    localparam int FUNC_W  = 4;
    localparam int MAX_OUT = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        m_req_valid;
    logic [NUM_REQ-1:0]        m_req_ready;
    logic [NUM_REQ*ID_W-1:0]   m_req_id;
    logic [NUM_REQ*8-1:0]      m_req_cfu;
    logic [NUM_REQ*FUNC_W-1:0] m_req_func;
    logic [NUM_REQ*32-1:0]     m_req_data0;
    logic [NUM_REQ*32-1:0]     m_req_data1;
    logic [NUM_REQ-1:0]        m_lock;
    logic [NUM_REQ-1:0]        m_resp_valid;
    logic [NUM_REQ-1:0]        m_resp_ready;
    logic [ID_W-1:0]           m_resp_id;
    logic                      m_resp_status;
    logic [31:0]               m_resp_data;
    logic                      s_req_valid;
    logic [ID_W-1:0]           s_req_id;
    logic [7:0]                s_req_cfu;
    logic [FUNC_W-1:0]         s_req_func;
    logic [31:0]               s_req_data0;
    logic [31:0]               s_req_data1;
    logic                      s_req_ready;
    logic                      s_resp_valid;
    logic [ID_W-1:0]           s_resp_id;
    logic                      s_resp_status;
    logic [31:0]               s_resp_data;
    logic                      s_resp_ready;
    logic                      err;

    int checks   = 0;
    int failures = 0;

    cfu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .FUNC_W  (FUNC_W),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .m_req_valid_i   (m_req_valid),
        .m_req_ready_o   (m_req_ready),
        .m_req_id_i      (m_req_id),
        .m_req_cfu_i     (m_req_cfu),
        .m_req_func_i    (m_req_func),
        .m_req_data0_i   (m_req_data0),
        .m_req_data1_i   (m_req_data1),
        .m_lock_i        (m_lock),
        .m_resp_valid_o  (m_resp_valid),
        .m_resp_ready_i  (m_resp_ready),
        .m_resp_id_o     (m_resp_id),
        .m_resp_status_o (m_resp_status),
        .m_resp_data_o   (m_resp_data),
        .s_req_valid_o   (s_req_valid),
        .s_req_id_o      (s_req_id),
        .s_req_cfu_o     (s_req_cfu),
        .s_req_func_o    (s_req_func),
        .s_req_data0_o   (s_req_data0),
        .s_req_data1_o   (s_req_data1),
        .s_req_ready_i   (s_req_ready),
        .s_resp_valid_i  (s_resp_valid),
        .s_resp_id_i     (s_resp_id),
        .s_resp_status_i (s_resp_status),
        .s_resp_data_i   (s_resp_data),
        .s_resp_ready_o  (s_resp_ready),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [ID_W-1:0] id, input logic [7:0] cfu,
                           input logic [FUNC_W-1:0] func, input logic [31:0] d0,
                           input logic [31:0] d1, input logic lock);
        m_req_valid[i]               = 1'b1;
        m_req_id[i*ID_W +: ID_W]     = id;
        m_req_cfu[i*8 +: 8]          = cfu;
        m_req_func[i*FUNC_W +: FUNC_W] = func;
        m_req_data0[i*32 +: 32]      = d0;
        m_req_data1[i*32 +: 32]      = d1;
        m_lock[i]                    = lock;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_req_valid = '0; m_req_id = '0; m_req_cfu = '0; m_req_func = '0;
        m_req_data0 = '0; m_req_data1 = '0; m_lock = '0; m_resp_ready = '0;
        s_req_ready = 1'b0; s_resp_valid = 1'b0; s_resp_id = '0;
        s_resp_status = 1'b0; s_resp_data = '0;
        tick();
        tick();
        check("rst_m_req_ready", m_req_ready, 0);
        check("rst_m_resp_valid", m_resp_valid, 0);
        check("rst_s_req_valid", s_req_valid, 0);
        check("rst_s_resp_ready", s_resp_ready, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // ---------------- single transaction from req0 ----------------
        do_reset();
        set_req(0, 4'h3, 8'h01, 4'h0, 32'h12345678, 32'h0BADF00D, 1'b0);
        s_req_ready = 1'b1;
        #1;
        check("t1_s_req_valid", s_req_valid, 1);
        check("t1_s_req_id", s_req_id, 4'h3);
        check("t1_s_req_cfu", s_req_cfu, 8'h01);
        check("t1_s_req_func", s_req_func, 4'h0);
        check("t1_s_req_data0", s_req_data0, 32'h12345678);
        check("t1_s_req_data1", s_req_data1, 32'h0BADF00D);
        check("t1_m_req_ready", m_req_ready, 2'b01);
        tick();
        m_req_valid = '0; s_req_ready = 1'b0;
        s_resp_valid = 1'b1; s_resp_id = 4'h3; s_resp_data = 32'hABCD;
        s_resp_status = 1'b1; m_resp_ready = 2'b01;
        #1;
        check("t1_m_resp_valid", m_resp_valid, 2'b01);
        check("t1_m_resp_data", m_resp_data, 32'hABCD);
        check("t1_m_resp_id", m_resp_id, 4'h3);
        check("t1_m_resp_status", m_resp_status, 1);
        check("t1_s_resp_ready", s_resp_ready, 1);
        tick();
        s_resp_valid = 1'b0; s_resp_status = 1'b0;
        #1;
        check("t1_resp_done", m_resp_valid, 0);
        check("t1_err", err, 0);

        // ---------------- round-robin alternation ----------------
        do_reset();
        set_req(0, 4'hA, 8'h00, 4'h1, 32'h0, 32'h0, 1'b0);
        set_req(1, 4'hB, 8'h00, 4'h2, 32'h0, 32'h0, 1'b0);
        s_req_ready = 1'b1; m_resp_ready = 2'b11;
        #1;
        check("t2_a_ready", m_req_ready, 2'b01);
        check("t2_a_id", s_req_id, 4'hA);
        tick();
        s_resp_valid = 1'b1; s_resp_id = 4'hA;
        #1;
        check("t2_b_ready", m_req_ready, 2'b10);
        check("t2_b_id", s_req_id, 4'hB);
        check("t2_b_resp", m_resp_valid, 2'b01);
        tick();
        s_resp_id = 4'hB;
        #1;
        check("t2_c_ready", m_req_ready, 2'b01);
        check("t2_c_resp", m_resp_valid, 2'b10);
        tick();
        s_resp_id = 4'hA;
        #1;
        check("t2_d_ready", m_req_ready, 2'b10);
        check("t2_d_resp", m_resp_valid, 2'b01);
        tick();
        m_req_valid = '0; s_resp_id = 4'hB;
        #1;
        check("t2_e_resp", m_resp_valid, 2'b10);
        check("t2_e_s_req_valid", s_req_valid, 0);
        tick();
        s_resp_valid = 1'b0;
        #1;
        check("t2_err", err, 0);

        // ---------------- full FIFO blocks third request ----------------
        do_reset();
        set_req(0, 4'h5, 8'h02, 4'h3, 32'h1, 32'h2, 1'b0);
        s_req_ready = 1'b1;
        #1;
        check("t3_first_ready", m_req_ready, 2'b01);
        tick();
        #1;
        check("t3_second_ready", m_req_ready, 2'b01);
        tick();
        #1;
        check("t3_full_ready", m_req_ready, 2'b00);
        check("t3_full_s_req_valid", s_req_valid, 0);
        tick();
        s_resp_valid = 1'b1; m_resp_ready = 2'b01; s_resp_id = 4'h5;
        #1;
        check("t3_full_pop_ready", m_req_ready, 2'b00);
        check("t3_full_pop_s_resp_ready", s_resp_ready, 1);
        tick();
        s_resp_valid = 1'b0;
        #1;
        check("t3_after_pop_ready", m_req_ready, 2'b01);
        m_req_valid = '0;
        tick();

        // ---------------- head requester stalls response ----------------
        // One tag for requester 0 is outstanding; requester 1 is ready but not head.
        s_resp_valid = 1'b1; m_resp_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("t4_stall_s_resp_ready", s_resp_ready, 0);
            check("t4_stall_m_resp_valid", m_resp_valid, 2'b01);
            tick();
        end
        m_resp_ready = 2'b01;
        #1;
        check("t4_release_s_resp_ready", s_resp_ready, 1);
        tick();
        s_resp_valid = 1'b0;
        #1;
        check("t4_err", err, 0);

        // ---------------- stray response sets sticky err ----------------
        s_resp_valid = 1'b1; m_resp_ready = 2'b11;
        #1;
        check("t5_stray_s_resp_ready", s_resp_ready, 0);
        check("t5_stray_m_resp_valid", m_resp_valid, 0);
        tick();
        s_resp_valid = 1'b0;
        #1;
        check("t5_err_set", err, 1);
        tick();
        tick();
        check("t5_err_sticky", err, 1);
        do_reset();

`ifdef CFU_ARB_LOCK_EN
        // ---------------- lock: atomic SHA readout by req1 ----------------
        set_req(1, 4'h1, 8'h03, 4'd6, 32'h0, 32'h0, 1'b1);
        s_req_ready = 1'b1; m_resp_ready = 2'b11;
        #1;
        check("t6_lock_take", m_req_ready, 2'b10);
        tick();
        set_req(0, 4'h0, 8'h03, 4'd0, 32'h0, 32'h0, 1'b0);
        m_req_valid[1] = 1'b0;
        #1;
        check("t6_owner_idle_ready", m_req_ready, 2'b00);
        check("t6_owner_idle_s_req_valid", s_req_valid, 0);
        s_resp_valid = 1'b1;
        tick();
        s_resp_valid = 1'b0;
        for (int f = 7; f <= 12; f++) begin
            set_req(1, 4'h1, 8'h03, FUNC_W'(f), 32'h0, 32'h0, 1'b1);
            s_resp_valid = (f != 7);
            #1;
            check("t6_locked_ready", m_req_ready, 2'b10);
            check("t6_locked_func", s_req_func, FUNC_W'(f));
            tick();
        end
        set_req(1, 4'h1, 8'h03, 4'd13, 32'h0, 32'h0, 1'b0);
        #1;
        check("t6_release_ready", m_req_ready, 2'b10);
        check("t6_release_func", s_req_func, 4'd13);
        tick();
        m_req_valid[1] = 1'b0;
        #1;
        check("t6_req0_granted", m_req_ready, 2'b01);
        check("t6_err", err, 0);
        tick();
        s_resp_valid = 1'b0; m_req_valid = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
